// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor MEM stage.
//
// A word-organised RAM with byte enables sits behind a valid/ready request
// channel and a valid/ready response channel. Only one transaction is in
// flight at a time. After a request is accepted the block waits LATENCY
// cycles, performs the RAM access, and then holds a response beat until the
// requester takes it.
//
// Parameters:
//   ADDR_W      byte address width
//   DEPTH_WORDS number of 32-bit words (power of two, >= 2)
//   LATENCY     wait cycles between accept and access (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   req_valid  request present               req_ready  responder idle
//   req_write  1 = store, 0 = load           req_addr   byte address
//   req_wdata  store data                    req_be     store byte enables
//   rsp_valid  response present              rsp_ready  requester takes response
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    error response
//   busy       transaction in flight
//
// Optional feature (macro MISALIGN_ERR_EN): when defined, a request whose
// req_addr[1:0] is non-zero skips the RAM and answers with rsp_err=1 and
// rsp_rdata=0. When undefined the low address bits are ignored and rsp_err
// is always 0.

module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       cnt_r;
  logic             busy_r;

  // Captured request
  logic             wr_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      wdata_r;
  logic [3:0]       be_r;
  logic             mis_r;

  // Response beat
  logic             rsp_valid_r;
  logic [31:0]      rsp_rdata_r;
  logic             rsp_err_r;

  logic [31:0]      mem_r [DEPTH_WORDS];

  logic             accept_s;
  logic             req_mis_s;
  logic [IDX_W-1:0] req_idx_s;
  logic             do_access_s;
  logic             acc_wr_s;
  logic             acc_mis_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic [31:0]      acc_wdata_s;
  logic [3:0]       acc_be_s;
  logic             mem_we_s;
  logic [31:0]      rd_word_s;
  logic             unused_addr_s;

  // Upper address bits wrap the RAM; they only feed this reduction.
  assign unused_addr_s = ^req_addr;

  assign req_idx_s = req_addr[IDX_W+1:2];
  assign req_ready = rst && (state_r == ST_IDLE);
  assign accept_s  = req_valid && req_ready;

`ifdef MISALIGN_ERR_EN
  assign req_mis_s = (req_addr[1:0] != 2'b00);
`else
  assign req_mis_s = 1'b0;
`endif

  // Access operands: a zero-latency accept uses the live request, otherwise
  // the copy captured at accept time (later request traffic is ignored).
  always_comb begin
    do_access_s = 1'b0;
    acc_wr_s    = wr_r;
    acc_mis_s   = mis_r;
    acc_idx_s   = idx_r;
    acc_wdata_s = wdata_r;
    acc_be_s    = be_r;
    if (state_r == ST_IDLE) begin
      do_access_s = accept_s && (LAT_C == 4'd0);
      acc_wr_s    = req_write;
      acc_mis_s   = req_mis_s;
      acc_idx_s   = req_idx_s;
      acc_wdata_s = req_wdata;
      acc_be_s    = req_be;
    end else begin
      do_access_s = rst && (state_r == ST_WAIT) && (cnt_r == 4'd1);
    end
  end

  assign mem_we_s  = do_access_s && acc_wr_s && !acc_mis_s;
  assign rd_word_s = mem_r[acc_idx_s];

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LAT_C == 4'd0) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Request capture and wait-state counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
      mis_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= LAT_C;
      wr_r    <= req_write;
      idx_r   <= req_idx_s;
      wdata_r <= req_wdata;
      be_r    <= req_be;
      mis_r   <= req_mis_s;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Response beat: loaded at the access edge, cleared when taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else if (do_access_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= acc_mis_s;
      rsp_rdata_r <= (acc_wr_s || acc_mis_s) ? 32'd0 : rd_word_s;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be_s[b]) begin
          mem_r[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Three instances with LATENCY 2, 0
// and 4 run side by side, each with its own stimulus and its own
// transaction-level reference model (RAM array + "cycles since accept").
module tb_dmem_responder;

  localparam int N     = 3;
  localparam int NDIR  = 12;
  localparam int MAXC  = 4000;
  localparam int DEPTH = 256;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          has_lit;
    logic [31:0] lit;
    bit          lit_err;
    int          stall;
    int          rst_at;
  } dreq_t;

  logic           clk;
  logic [N-1:0]   rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0]    req_addr [N];
  logic [31:0]    req_wdata [N];
  logic [31:0]    rsp_rdata [N];
  logic [3:0]     req_be [N];

  int n_checks;
  int n_errors;

  // Reference model state
  bit          m_ok [N], m_busy [N], m_wr [N], m_mis [N], m_err [N], m_has_lit [N], m_lit_err [N];
  int          m_age [N], m_rcyc [N], m_kind [N], m_stall [N], m_rst_at [N];
  int          init_idx [N], dptr [N], n_rand [N], cur_kind [N];
  logic [7:0]  m_idx [N];
  logic [31:0] m_wdata [N], m_rdata [N], m_lit [N];
  logic [3:0]  m_be [N];
  logic [31:0] mem_m [N][DEPTH];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(lat_of(g))
    ) dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g]), .busy(busy[g])
    );
  end

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k, input int i);
    return {16'hA5A5, 8'(k), 8'(i)};
  endfunction

  // Directed transactions with hand-computed expected responses.
  function automatic dreq_t get_dir(input int n, input int k);
    dreq_t r;
    logic [31:0] w20;
    r.wr = 1'b0; r.addr = 32'h10; r.wdata = 32'h0; r.be = 4'hF;
    r.has_lit = 1'b1; r.lit = 32'h0; r.lit_err = 1'b0; r.stall = 0; r.rst_at = 0;
`ifdef MISALIGN_ERR_EN
    w20 = {16'hA5A5, 8'(k), 8'h08};
`else
    w20 = 32'hAAAA_AAAA;
`endif
    case (n)
      0: begin r.wr = 1'b1; r.wdata = 32'hDEAD_BEEF; end
      1: r.lit = 32'hDEAD_BEEF;
      2: begin r.wr = 1'b1; r.wdata = 32'h1122_3344; r.be = 4'b0101; end
      3: begin r.lit = 32'hDE22_BE44; r.stall = 5; end
      4: begin r.wr = 1'b1; r.wdata = 32'hFFFF_FFFF; r.be = 4'b0000; end
      5: r.lit = 32'hDE22_BE44;
      6: begin r.addr = 32'h410; r.lit = 32'hDE22_BE44; end
      7: begin
        r.addr = 32'h13;
`ifdef MISALIGN_ERR_EN
        r.lit = 32'h0; r.lit_err = 1'b1;
`else
        r.lit = 32'hDE22_BE44;
`endif
      end
      8: begin
        r.wr = 1'b1; r.addr = 32'h22; r.wdata = 32'hAAAA_AAAA;
`ifdef MISALIGN_ERR_EN
        r.lit_err = 1'b1;
`endif
      end
      9: begin r.addr = 32'h20; r.lit = w20; end
      10: begin r.wr = 1'b1; r.addr = 32'h20; r.wdata = 32'h1234_5678; r.has_lit = 1'b0; r.rst_at = 2; end
      default: begin r.addr = 32'h20; r.lit = (lat_of(k) >= 2) ? w20 : 32'h1234_5678; end
    endcase
    return r;
  endfunction

  task automatic check1(input string name, input int k, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d (LATENCY=%0d) cycle %0d: got %b, expected %b", name, k, lat_of(k), cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input int k, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d (LATENCY=%0d) cycle %0d: got %h, expected %h", name, k, lat_of(k), cyc, act, exp);
    end
  endtask

  task automatic access(input int k);
    if (m_mis[k]) begin
      m_rdata[k] = 32'h0; m_err[k] = 1'b1;
    end else if (m_wr[k]) begin
      for (int b = 0; b < 4; b++)
        if (m_be[k][b]) mem_m[k][m_idx[k]][8*b +: 8] = m_wdata[k][8*b +: 8];
      m_rdata[k] = 32'h0; m_err[k] = 1'b0;
    end else begin
      m_rdata[k] = mem_m[k][m_idx[k]]; m_err[k] = 1'b0;
    end
  endtask

  // The access happens at the edge LATENCY cycles after the accept edge.
  task automatic advance(input int k);
    if (m_age[k] == lat_of(k)) access(k);
    m_age[k]++;
  endtask

  task automatic model_step();
    dreq_t d;
    for (int k = 0; k < N; k++) begin
      if (!rst[k]) begin
        m_busy[k] = 1'b0; m_age[k] = 0; m_ok[k] = 1'b1;
      end else if (!m_busy[k]) begin
        if (req_valid[k]) begin
          m_busy[k] = 1'b1; m_age[k] = 0; m_rcyc[k] = 0;
          m_wr[k] = req_write[k]; m_idx[k] = req_addr[k][9:2];
          m_wdata[k] = req_wdata[k]; m_be[k] = req_be[k];
`ifdef MISALIGN_ERR_EN
          m_mis[k] = (req_addr[k][1:0] != 2'b00);
`else
          m_mis[k] = 1'b0;
`endif
          m_kind[k] = cur_kind[k];
          m_has_lit[k] = 1'b0; m_stall[k] = 0; m_rst_at[k] = 0;
          if (cur_kind[k] == 1) begin
            init_idx[k]++;
          end else if (cur_kind[k] == 2) begin
            d = get_dir(dptr[k], k);
            m_has_lit[k] = d.has_lit; m_lit[k] = d.lit; m_lit_err[k] = d.lit_err;
            m_stall[k] = d.stall; m_rst_at[k] = d.rst_at;
            dptr[k]++;
          end else begin
            n_rand[k]++;
          end
          advance(k);
        end
      end else if (m_age[k] > lat_of(k)) begin
        if (rsp_ready[k]) m_busy[k] = 1'b0;
        else m_rcyc[k]++;
      end else begin
        advance(k);
      end
    end
  endtask

  task automatic compare(input int cyc);
    for (int k = 0; k < N; k++) begin
      bit ev;
      if (m_ok[k]) begin
        ev = m_busy[k] && (m_age[k] > lat_of(k));
        check1("req_ready", k, cyc, req_ready[k], rst[k] && !m_busy[k]);
        check1("rsp_valid", k, cyc, rsp_valid[k], ev);
        check32("rsp_rdata", k, cyc, rsp_rdata[k], ev ? m_rdata[k] : 32'h0);
        check1("rsp_err", k, cyc, rsp_err[k], ev ? m_err[k] : 1'b0);
        check1("busy", k, cyc, busy[k], m_busy[k]);
        if (ev && m_has_lit[k]) begin
          check32("lit_rdata", k, cyc, rsp_rdata[k], m_lit[k]);
          check1("lit_err", k, cyc, rsp_err[k], m_lit_err[k]);
        end
        if (cyc < 2) begin
          check1("rst_req_ready", k, cyc, req_ready[k], 1'b0);
          check1("rst_rsp_valid", k, cyc, rsp_valid[k], 1'b0);
          check1("rst_busy", k, cyc, busy[k], 1'b0);
        end
        if (cyc == 2) check1("req_ready_after_rst", k, cyc, req_ready[k], 1'b1);
      end
    end
  endtask

  task automatic drive(input int c);
    dreq_t d;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'($urandom_range(0, 1));
      req_write[k] = 1'($urandom_range(0, 1));
      req_addr[k]  = $urandom;
      req_wdata[k] = $urandom;
      req_be[k]    = 4'($urandom_range(0, 15));
      rsp_ready[k] = 1'($urandom_range(0, 1));
      rst[k]       = 1'b1;
      cur_kind[k]  = 0;
      if (c < 2) begin
        rst[k] = 1'b0; req_valid[k] = 1'b0;
      end else if (c < 3) begin
        req_valid[k] = 1'b0;
      end else if (m_busy[k]) begin
        if (m_age[k] > lat_of(k)) begin
          if (m_kind[k] == 2)      rsp_ready[k] = (m_rcyc[k] >= m_stall[k]);
          else if (m_kind[k] == 1) rsp_ready[k] = 1'b1;
          else                     rsp_ready[k] = ($urandom_range(0, 3) != 0);
        end else if (m_kind[k] == 2 && m_rst_at[k] != 0 && m_age[k] == m_rst_at[k]) begin
          rst[k] = 1'b0;
        end
        if (m_kind[k] == 0 && $urandom_range(0, 79) == 0) rst[k] = 1'b0;
      end else if (init_idx[k] < 16) begin
        req_valid[k] = 1'b1; req_write[k] = 1'b1; req_be[k] = 4'hF;
        req_addr[k] = 32'(init_idx[k]) << 2;
        req_wdata[k] = init_word(k, init_idx[k]);
        cur_kind[k] = 1;
      end else if (dptr[k] < NDIR) begin
        d = get_dir(dptr[k], k);
        req_valid[k] = 1'b1; req_write[k] = d.wr; req_addr[k] = d.addr;
        req_wdata[k] = d.wdata; req_be[k] = d.be;
        cur_kind[k] = 2;
      end else begin
        req_valid[k] = ($urandom_range(0, 2) != 0);
        req_addr[k]  = $urandom & 32'hFFFF_FC3F;
        if ($urandom_range(0, 79) == 0) rst[k] = 1'b0;
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_errors = 0;
    for (int k = 0; k < N; k++) begin
      m_ok[k] = 1'b0; m_busy[k] = 1'b0; m_age[k] = 0; m_rcyc[k] = 0; m_kind[k] = 0;
      m_has_lit[k] = 1'b0; init_idx[k] = 0; dptr[k] = 0; n_rand[k] = 0;
    end
    drive(0);
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare(cyc);
      drive(cyc + 1);
    end
    for (int k = 0; k < N; k++) begin
      check1("directed_done", k, MAXC, (init_idx[k] == 16) && (dptr[k] == NDIR), 1'b1);
      check1("random_traffic", k, MAXC, n_rand[k] > 20, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
